register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter WIDTH, default 16: data width of every register and port.
REQ-002 Parameter DEPTH, default 16: number of registers; legal range 2..256.
REQ-003 Parameter ZERO_REG, default 1: 1 means register 0 is hard-wired to zero.
REQ-004 Local constant AW SHALL equal clog2(DEPTH) and size all address ports.
REQ-005 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-006 Reset  input  1  reset, synchronous and active-high.
REQ-007 RegWrite  input  1  write enable for the write port.
REQ-008 WriteAddr  input  AW  write register index.
REQ-009 WriteData  input  WIDTH  write data.
REQ-010 ReadAddrA, ReadAddrB  input  AW  read register indices, one per read port.
REQ-011 ReadDataA, ReadDataB  output  WIDTH  read data, one per read port.
REQ-012 ValidA, ValidB  output  1  high when the addressed register has been written since the last reset.
REQ-013 WriteCount  output  16  number of accepted writes since reset.

Function
REQ-014 When RegWrite=1 and Reset=0 at a rising CLK edge, the module SHALL load WriteData into register WriteAddr.
- The write is visible on the read ports from the following cycle.
REQ-015 Reads SHALL be combinational: ReadDataX equals the current contents of register ReadAddrX, with no clock latency.
REQ-016 Address decoding SHALL handle out-of-range addresses (address >= DEPTH):
- a write to such an address is ignored and not counted;
- a read from such an address returns 0 with Valid low.
REQ-017 With ZERO_REG=1, writes to register 0 SHALL be discarded and not counted; reads of register 0 return 0 with Valid high.
REQ-018 Each register SHALL have a valid bit that is set on an accepted write and cleared only by reset.
REQ-019 WriteCount SHALL increment by 1 on each accepted write and saturate at 16'hFFFF; it does not wrap.
REQ-020 Both read ports SHALL operate independently; the same address on both ports returns identical data.
REQ-021 There is no internal state machine beyond the storage, the valid bits and the counter; all outputs are derived combinationally from that state.

Reset
REQ-022 When Reset=1 at a rising CLK edge, the module SHALL clear all registers to 0, all valid bits to 0 and WriteCount to 0.
REQ-023 Reset SHALL take priority over a simultaneous write; that write is lost and not counted.
REQ-024 With no bypass in effect, every output SHALL be 0 in the cycle after reset.
- Exception: ValidX is 1 when ZERO_REG=1 and ReadAddrX=0.
REQ-025 Reset deasserted mid-sequence SHALL have no effect on the cycle of deassertion; writes resume on the next edge.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
- Defined: when RegWrite=1, Reset=0 and ReadAddrX equals a writable, in-range WriteAddr, ReadDataX shows WriteData and ValidX=1 in the same cycle.
- Undefined: the read port shows the old contents until after the edge.
REQ-027 Bypass SHALL never forward to register 0 when ZERO_REG=1, nor while Reset=1.

Structure
REQ-028 A shared package regfile_pkg SHALL hold the default WIDTH and DEPTH, the WriteCount width (16) and its saturation constant.
REQ-029 One sub-module, register_cell, SHALL be instantiated DEPTH times.
- Contents: a WIDTH-bit register plus its valid bit, with synchronous active-high reset and a load enable.
REQ-030 Write decode, read multiplexing, bypass and the counter SHALL reside in register_file itself.

Verification
REQ-031 Reset, then write 20 to r3, then read A=3 next cycle -> ReadDataA=20, ValidA=1, WriteCount=1.
REQ-032 Write 16'h1234 to r0 with ZERO_REG=1 -> ReadDataA=0, ValidA=1, WriteCount unchanged.
REQ-033 Hold RegWrite=1 with WriteAddr=5, WriteData=40 and ReadAddrB=5 in the same cycle:
- REGFILE_BYPASS_EN defined -> ReadDataB=40 before the edge;
- undefined -> ReadDataB=0 before the edge and 40 after.
REQ-034 Write r7=60, then assert Reset together with a write r7=80 -> next cycle ReadDataA(7)=0, ValidA=0, WriteCount=0.
REQ-035 DEPTH=12: write 99 to address 13 -> ignored, read of 13 returns 0 with Valid=0, WriteCount unchanged.
REQ-036 Perform 65540 accepted writes -> WriteCount stays at 16'hFFFF.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and write-counter constants for register_file
package regfile_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_DEPTH = 16;

  // Accepted-write counter width and the value it saturates at.
  localparam int               WCOUNT_W   = 16;
  localparam logic [WCOUNT_W-1:0] WCOUNT_MAX = 16'hFFFF;

  // Saturating increment: holds at WCOUNT_MAX instead of wrapping.
  function automatic logic [WCOUNT_W-1:0] sat_inc(input logic [WCOUNT_W-1:0] v);
    return (v == WCOUNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/register_cell.sv
// rtl/register_cell.sv - one storage word plus its written-since-reset flag
module register_cell
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  // Reset clears word and flag; a load captures data and marks the word valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 1W/2R register file with valid bits and write counter (option: REGFILE_BYPASS_EN)
module register_file
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                RegWrite,
  input  logic [AW-1:0]       WriteAddr,
  input  logic [WIDTH-1:0]    WriteData,
  input  logic [AW-1:0]       ReadAddrA,
  input  logic [AW-1:0]       ReadAddrB,
  output logic [WIDTH-1:0]    ReadDataA,
  output logic [WIDTH-1:0]    ReadDataB,
  output logic                ValidA,
  output logic                ValidB,
  output logic [WCOUNT_W-1:0] WriteCount
);

  logic [WIDTH-1:0] cell_q     [DEPTH];
  logic             cell_valid [DEPTH];
  logic [DEPTH-1:0] cell_load;
  logic             wr_accept;
  logic             wr_in_range;
  logic             wr_is_zero;

  // A write is accepted only for an in-range, writable address outside reset.
  always_comb begin
    wr_in_range = ({1'b0, WriteAddr} < (AW+1)'(DEPTH));
    wr_is_zero  = (ZERO_REG != 0) && (WriteAddr == '0);
    wr_accept   = RegWrite && !Reset && wr_in_range && !wr_is_zero;
    cell_load   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_accept && (WriteAddr == AW'(i))) cell_load[i] = 1'b1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_cell
      register_cell #(.WIDTH(WIDTH)) u_cell (
        .clk   (CLK),
        .reset (Reset),
        .load  (cell_load[g]),
        .d     (WriteData),
        .q     (cell_q[g]),
        .valid (cell_valid[g])
      );
    end
  endgenerate

  // Read mux per port; out-of-range reads give 0/invalid, register 0 reads as a valid zero.
  always_comb begin
    ReadDataA = '0;
    ValidA    = 1'b0;
    ReadDataB = '0;
    ValidB    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ReadAddrA == AW'(i)) begin
        ReadDataA = cell_q[i];
        ValidA    = cell_valid[i];
      end
      if (ReadAddrB == AW'(i)) begin
        ReadDataB = cell_q[i];
        ValidB    = cell_valid[i];
      end
    end
    if ((ZERO_REG != 0) && (ReadAddrA == '0)) begin
      ReadDataA = '0;
      ValidA    = 1'b1;
    end
    if ((ZERO_REG != 0) && (ReadAddrB == '0)) begin
      ReadDataB = '0;
      ValidB    = 1'b1;
    end
`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight write; wr_accept already excludes reset and register 0.
    if (wr_accept && (ReadAddrA == WriteAddr)) begin
      ReadDataA = WriteData;
      ValidA    = 1'b1;
    end
    if (wr_accept && (ReadAddrB == WriteAddr)) begin
      ReadDataB = WriteData;
      ValidB    = 1'b1;
    end
`endif
  end

  // Count accepted writes, saturating rather than wrapping.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      WriteCount <= '0;
    end else if (wr_accept) begin
      WriteCount <= sat_inc(WriteCount);
    end
  end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;

  localparam int WIDTH = 16;
  localparam int DEPTH = 12;
  localparam int AW    = 4;

`ifdef REGFILE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             Reset;
  logic             RegWrite;
  logic [AW-1:0]    WriteAddr;
  logic [WIDTH-1:0] WriteData;
  logic [AW-1:0]    ReadAddrA;
  logic [AW-1:0]    ReadAddrB;
  logic [WIDTH-1:0] ReadDataA;
  logic [WIDTH-1:0] ReadDataB;
  logic             ValidA;
  logic             ValidB;
  logic [15:0]      WriteCount;

  int passed = 0;
  int total  = 0;

  register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .RegWrite   (RegWrite),
    .WriteAddr  (WriteAddr),
    .WriteData  (WriteData),
    .ReadAddrA  (ReadAddrA),
    .ReadAddrB  (ReadAddrB),
    .ReadDataA  (ReadDataA),
    .ReadDataB  (ReadDataB),
    .ValidA     (ValidA),
    .ValidB     (ValidB),
    .WriteCount (WriteCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    Reset = 1'b1; RegWrite = 1'b0; WriteAddr = '0; WriteData = '0;
    ReadAddrA = '0; ReadAddrB = '0;
    tick; tick;
    Reset = 1'b0;
    #1;
    chk("rst_dataA", ReadDataA, 0);
    chk("rst_validA_r0", ValidA, 1);
    chk("rst_count", WriteCount, 0);
    ReadAddrA = 3; ReadAddrB = 5; #1;
    chk("rst_validA_r3", ValidA, 0);
    chk("rst_dataB_r5", ReadDataB, 0);
    chk("rst_validB_r5", ValidB, 0);

    // write 20 to r3
    RegWrite = 1'b1; WriteAddr = 3; WriteData = 20;
    tick;
    RegWrite = 1'b0; ReadAddrA = 3; #1;
    chk("w3_data", ReadDataA, 20);
    chk("w3_valid", ValidA, 1);
    chk("w3_count", WriteCount, 1);

    // write to r0 is discarded
    RegWrite = 1'b1; WriteAddr = 0; WriteData = 16'h1234;
    tick;
    RegWrite = 1'b0; ReadAddrA = 0; #1;
    chk("r0_data", ReadDataA, 0);
    chk("r0_valid", ValidA, 1);
    chk("r0_count", WriteCount, 1);

    // same-cycle write/read of r5
    RegWrite = 1'b1; WriteAddr = 5; WriteData = 40; ReadAddrB = 5; #1;
    chk("byp_dataB", ReadDataB, BYP ? 40 : 0);
    chk("byp_validB", ValidB, BYP ? 1 : 0);
    tick;
    RegWrite = 1'b0; #1;
    chk("w5_dataB", ReadDataB, 40);
    chk("w5_validB", ValidB, 1);
    chk("w5_count", WriteCount, 2);

    // no forwarding to r0
    RegWrite = 1'b1; WriteAddr = 0; WriteData = 7; ReadAddrB = 0; #1;
    chk("byp_r0_dataB", ReadDataB, 0);
    tick;
    RegWrite = 1'b0; #1;
    chk("byp_r0_count", WriteCount, 2);

    // both ports on the same address
    ReadAddrA = 5; ReadAddrB = 5; #1;
    chk("dual_A", ReadDataA, 40);
    chk("dual_B", ReadDataB, 40);
    ReadAddrA = 3; #1;
    chk("indep_A", ReadDataA, 20);
    chk("indep_B", ReadDataB, 40);

    // write r7=60, then reset with a competing write r7=80
    RegWrite = 1'b1; WriteAddr = 7; WriteData = 60;
    tick;
    ReadAddrA = 7; WriteData = 80; Reset = 1'b1; #1;
    chk("rstw_noforward", ReadDataA, 60);
    chk("rstw_count_pre", WriteCount, 3);
    tick;
    Reset = 1'b0; RegWrite = 1'b0; #1;
    chk("rstw_data", ReadDataA, 0);
    chk("rstw_valid", ValidA, 0);
    chk("rstw_count", WriteCount, 0);
    ReadAddrB = 3; #1;
    chk("rstw_r3_valid", ValidB, 0);

    // out-of-range write/read at address 13
    RegWrite = 1'b1; WriteAddr = 13; WriteData = 99; ReadAddrA = 13; #1;
    chk("oor_data_pre", ReadDataA, 0);
    chk("oor_valid_pre", ValidA, 0);
    tick;
    RegWrite = 1'b0; #1;
    chk("oor_data", ReadDataA, 0);
    chk("oor_valid", ValidA, 0);
    chk("oor_count", WriteCount, 0);

    // counter saturation
    RegWrite = 1'b1; WriteAddr = 1; ReadAddrA = 1;
    for (int i = 1; i <= 65540; i++) begin
      WriteData = 16'(i);
      tick;
      if (i == 65534) chk("sat_fffe", WriteCount, 16'hFFFE);
      if (i == 65535) chk("sat_ffff", WriteCount, 16'hFFFF);
    end
    RegWrite = 1'b0; #1;
    chk("sat_hold", WriteCount, 16'hFFFF);
    chk("sat_r1_data", ReadDataA, 16'(65540));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
